// File: rtl/dmem_arb_pkg.sv
// Shared encodings for the two-master dmem AXI-Lite arbiter.
// Latency: none (constants and types only).
// Backpressure: not applicable.
package dmem_arb_pkg;

    // Number of masters sharing the dmem slave.
    localparam int NM = 2;

    typedef enum logic {
        W_IDLE = 1'b0,
        W_BUSY = 1'b1
    } wstate_e;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_BUSY = 1'b1
    } rstate_e;

endpackage

// File: rtl/dmem_axi_lite_arbiter_rr_arb2.sv
// Combinational 2-way round-robin picker: a lone requester wins, a tie goes to prio.
// Latency: zero, purely combinational.
// Backpressure: none; the caller registers gnt only when req is non-zero.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       prio,
    output logic       gnt
);

    // Lone requester wins outright; on a tie (or no request) the priority index is returned.
    always_comb begin
        case (req)
            2'b01:   gnt = 1'b0;
            2'b10:   gnt = 1'b1;
            default: gnt = prio;
        endcase
    end

endmodule

// File: rtl/dmem_axi_lite_arbiter.sv
// Two-master AXI-Lite arbiter in front of the dmem slave, independent round-robin read and write channels.
// Latency: one cycle from address valid to slave-side valid; slave responses return combinationally.
// Backpressure: grant held until the response handshake; the other master sees ready/valid at 0 and waits.
module dmem_axi_lite_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                           clk,
    input  logic                           resetn,
    // master side
    input  logic [NM*ADDR_WIDTH-1:0]       m_awaddr,
    input  logic [NM-1:0]                  m_awvalid,
    output logic [NM-1:0]                  m_awready,
    input  logic [NM*DATA_WIDTH-1:0]       m_wdata,
    input  logic [NM*(DATA_WIDTH/8)-1:0]   m_wstrb,
    input  logic [NM-1:0]                  m_wvalid,
    output logic [NM-1:0]                  m_wready,
    output logic [NM-1:0]                  m_bvalid,
    input  logic [NM-1:0]                  m_bready,
    input  logic [NM*ADDR_WIDTH-1:0]       m_araddr,
    input  logic [NM-1:0]                  m_arvalid,
    output logic [NM-1:0]                  m_arready,
    output logic [DATA_WIDTH-1:0]          m_rdata,
    output logic [NM-1:0]                  m_rvalid,
    input  logic [NM-1:0]                  m_rready,
    // slave side
    output logic [ADDR_WIDTH-1:0]          s_awaddr,
    output logic                           s_awvalid,
    input  logic                           s_awready,
    output logic [DATA_WIDTH-1:0]          s_wdata,
    output logic [DATA_WIDTH/8-1:0]        s_wstrb,
    output logic                           s_wvalid,
    input  logic                           s_wready,
    input  logic                           s_bvalid,
    output logic                           s_bready,
    output logic [ADDR_WIDTH-1:0]          s_araddr,
    output logic                           s_arvalid,
    input  logic                           s_arready,
    input  logic [DATA_WIDTH-1:0]          s_rdata,
    input  logic                           s_rvalid,
    output logic                           s_rready
);

    localparam int SW = DATA_WIDTH / 8;

    wstate_e wstate;
    rstate_e rstate;
    logic    wgrant, wprio, wpick;
    logic    rgrant, rprio, rpick;
    // Address/data phase already accepted by the slave; keeps a master that
    // starts its next request early from presenting a second beat inside one grant.
    logic    aw_done, w_done, ar_done;
    logic    wbusy, rbusy, wsel, rsel;

    rr_arb2 u_wpick (
        .req  (m_awvalid),
        .prio (wprio),
        .gnt  (wpick)
    );

    rr_arb2 u_rpick (
        .req  (m_arvalid),
        .prio (rprio),
        .gnt  (rpick)
    );

    // Write channel FSM: grant on any awvalid in IDLE, release on the granted master's B handshake.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wstate  <= W_IDLE;
            wgrant  <= 1'b0;
            wprio   <= 1'b0;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else begin
            case (wstate)
                W_IDLE: begin
                    aw_done <= 1'b0;
                    w_done  <= 1'b0;
                    if (|m_awvalid) begin
                        wgrant <= wpick;
                        wstate <= W_BUSY;
                    end
                end
                W_BUSY: begin
                    if (s_awvalid && s_awready) aw_done <= 1'b1;
                    if (s_wvalid && s_wready)   w_done  <= 1'b1;
                    if (s_bvalid && m_bready[wgrant]) begin
                        wprio  <= ~wgrant;
                        wstate <= W_IDLE;
                    end
                end
                default: wstate <= W_IDLE;
            endcase
        end
    end

    // Read channel FSM: same shape as the write side, released on the R handshake.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rstate  <= R_IDLE;
            rgrant  <= 1'b0;
            rprio   <= 1'b0;
            ar_done <= 1'b0;
        end else begin
            case (rstate)
                R_IDLE: begin
                    ar_done <= 1'b0;
                    if (|m_arvalid) begin
                        rgrant <= rpick;
                        rstate <= R_BUSY;
                    end
                end
                R_BUSY: begin
                    if (s_arvalid && s_arready) ar_done <= 1'b1;
                    if (s_rvalid && m_rready[rgrant]) begin
                        rprio  <= ~rgrant;
                        rstate <= R_IDLE;
                    end
                end
                default: rstate <= R_IDLE;
            endcase
        end
    end

    assign wbusy = (wstate == W_BUSY);
    assign rbusy = (rstate == R_BUSY);
    // Mux selects fall back to master 0 while idle.
    assign wsel  = wbusy & wgrant;
    assign rsel  = rbusy & rgrant;

    assign s_awaddr  = wsel ? m_awaddr[ADDR_WIDTH +: ADDR_WIDTH] : m_awaddr[0 +: ADDR_WIDTH];
    assign s_wdata   = wsel ? m_wdata[DATA_WIDTH +: DATA_WIDTH]  : m_wdata[0 +: DATA_WIDTH];
    assign s_wstrb   = wsel ? m_wstrb[SW +: SW]                  : m_wstrb[0 +: SW];
    assign s_araddr  = rsel ? m_araddr[ADDR_WIDTH +: ADDR_WIDTH] : m_araddr[0 +: ADDR_WIDTH];

    // The slave latches address while valid is high, so valids only leave the block in BUSY.
    assign s_awvalid = wbusy & ~aw_done & m_awvalid[wgrant];
    assign s_wvalid  = wbusy & ~w_done  & m_wvalid[wgrant];
    assign s_bready  = wbusy & m_bready[wgrant];
    assign s_arvalid = rbusy & ~ar_done & m_arvalid[rgrant];
    assign s_rready  = rbusy & m_rready[rgrant];

    assign m_rdata   = s_rdata;

    // Route write-side slave responses to the granted master only.
    always_comb begin
        m_awready = '0;
        m_wready  = '0;
        m_bvalid  = '0;
        if (wbusy) begin
            m_awready[wgrant] = s_awready & ~aw_done;
            m_wready[wgrant]  = s_wready & ~w_done;
            m_bvalid[wgrant]  = s_bvalid;
        end
    end

    // Route read-side slave responses to the granted master only.
    always_comb begin
        m_arready = '0;
        m_rvalid  = '0;
        if (rbusy) begin
            m_arready[rgrant] = s_arready & ~ar_done;
            m_rvalid[rgrant]  = s_rvalid;
        end
    end

endmodule

// File: tb/tb_dmem_axi_lite_arbiter.sv
// Self-checking bench: table of transactions, hand-written arbitration corner cases, randomized traffic.
// A simple memory model stands in for the dmem slave; expected read data comes from a bench-side array.
// Each phase waits on the DUT with a bounded cycle count.
module tb_dmem_axi_lite_arbiter;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int TMO = 200;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    logic [2*AW-1:0] m_awaddr, m_araddr;
    logic [2*DW-1:0] m_wdata;
    logic [7:0]      m_wstrb;
    logic [1:0]      m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
    logic [1:0]      m_arvalid, m_arready, m_rvalid, m_rready;
    logic [DW-1:0]   m_rdata;
    logic [AW-1:0]   s_awaddr, s_araddr;
    logic [DW-1:0]   s_wdata, s_rdata;
    logic [3:0]      s_wstrb;
    logic            s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
    logic            s_arvalid, s_arready, s_rvalid, s_rready;

    // per-master drive variables
    logic [31:0] awaddr_d [2];
    logic [31:0] wdata_d  [2];
    logic [3:0]  wstrb_d  [2];
    logic [31:0] araddr_d [2];
    logic        awv [2];
    logic        wv  [2];
    logic        br  [2];
    logic        arv [2];
    logic        rr  [2];

    assign m_awaddr  = {awaddr_d[1], awaddr_d[0]};
    assign m_wdata   = {wdata_d[1], wdata_d[0]};
    assign m_wstrb   = {wstrb_d[1], wstrb_d[0]};
    assign m_araddr  = {araddr_d[1], araddr_d[0]};
    assign m_awvalid = {awv[1], awv[0]};
    assign m_wvalid  = {wv[1], wv[0]};
    assign m_bready  = {br[1], br[0]};
    assign m_arvalid = {arv[1], arv[0]};
    assign m_rready  = {rr[1], rr[0]};

    dmem_axi_lite_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .resetn(resetn),
        .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
        .m_bvalid(m_bvalid), .m_bready(m_bready),
        .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_rdata(m_rdata), .m_rvalid(m_rvalid), .m_rready(m_rready),
        .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
        .s_bvalid(s_bvalid), .s_bready(s_bready),
        .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rdata(s_rdata), .s_rvalid(s_rvalid), .s_rready(s_rready)
    );

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++)
            if (s[b]) r[b*8 +: 8] = d[b*8 +: 8];
        return r;
    endfunction

    // ---------------- dmem slave stand-in ----------------
    logic        sl_got_aw, sl_got_w;
    logic [31:0] sl_a, sl_d;
    logic [3:0]  sl_s;
    logic [31:0] smem [256];

    assign s_awready = !sl_got_aw && !s_bvalid;
    assign s_wready  = !sl_got_w && !s_bvalid;
    assign s_arready = !s_rvalid;

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sl_got_aw <= 1'b0;
            sl_got_w  <= 1'b0;
            s_bvalid  <= 1'b0;
            s_rvalid  <= 1'b0;
            s_rdata   <= '0;
        end else begin
            if (s_awvalid && s_awready) begin sl_got_aw <= 1'b1; sl_a <= s_awaddr; end
            if (s_wvalid && s_wready) begin sl_got_w <= 1'b1; sl_d <= s_wdata; sl_s <= s_wstrb; end
            if (sl_got_aw && sl_got_w) begin
                smem[sl_a[9:2]] <= merge(smem[sl_a[9:2]], sl_d, sl_s);
                s_bvalid  <= 1'b1;
                sl_got_aw <= 1'b0;
                sl_got_w  <= 1'b0;
            end
            if (s_bvalid && s_bready) s_bvalid <= 1'b0;
            if (s_arvalid && s_arready) begin s_rvalid <= 1'b1; s_rdata <= smem[s_araddr[9:2]]; end
            if (s_rvalid && s_rready) s_rvalid <= 1'b0;
        end
    end

    // ---------------- bookkeeping ----------------
    int n_chk = 0, n_pass = 0, viol = 0, cyc = 0;
    int aw_m[$], aw_c[$], b_m[$], b_c[$], ar_m[$], ar_c[$], r_m[$], r_c[$];
    logic [31:0] mdl [256];

    always @(posedge clk) cyc <= cyc + 1;

    // handshake log, sampled mid-cycle
    always @(negedge clk) begin
        if (resetn) begin
            for (int m = 0; m < 2; m++) begin
                if (m_awvalid[m] && m_awready[m]) begin aw_m.push_back(m); aw_c.push_back(cyc); end
                if (m_bvalid[m] && m_bready[m])   begin b_m.push_back(m);  b_c.push_back(cyc);  end
                if (m_arvalid[m] && m_arready[m]) begin ar_m.push_back(m); ar_c.push_back(cyc); end
                if (m_rvalid[m] && m_rready[m])   begin r_m.push_back(m);  r_c.push_back(cyc);  end
            end
            if (m_awready == 2'b11 || m_wready == 2'b11 || m_bvalid == 2'b11 ||
                m_arready == 2'b11 || m_rvalid == 2'b11) viol++;
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    endtask

    task automatic clr_logs();
        aw_m.delete(); aw_c.delete(); b_m.delete(); b_c.delete();
        ar_m.delete(); ar_c.delete(); r_m.delete(); r_c.delete();
    endtask

    task automatic clr_drv();
        for (int m = 0; m < 2; m++) begin
            awaddr_d[m] = '0; wdata_d[m] = '0; wstrb_d[m] = '0; araddr_d[m] = '0;
            awv[m] = 1'b0; wv[m] = 1'b0; br[m] = 1'b0; arv[m] = 1'b0; rr[m] = 1'b0;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        resetn = 1'b0;
        clr_drv();
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;
        clr_logs();
    endtask

    // Master write: called at posedge+1, returns at posedge+1.
    task automatic mwrite(input int m, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, input int bdly);
        bit awd, wdd, hs_aw, hs_w, done;
        int t;
        awd = 0; wdd = 0; t = 0;
        awaddr_d[m] = a; wdata_d[m] = d; wstrb_d[m] = s;
        awv[m] = 1'b1; wv[m] = 1'b1;
        while (!(awd && wdd) && t < TMO) begin
            @(negedge clk);
            hs_aw = awv[m] && m_awready[m];
            hs_w  = wv[m] && m_wready[m];
            @(posedge clk); #1;
            if (hs_aw) begin awv[m] = 1'b0; awd = 1; end
            if (hs_w)  begin wv[m] = 1'b0;  wdd = 1; end
            t++;
        end
        awv[m] = 1'b0; wv[m] = 1'b0;
        chk("wr_addr_data_hs", {62'd0, awd, wdd}, 64'd3);
        if (bdly > 0) begin repeat (bdly) @(posedge clk); #1; end
        br[m] = 1'b1; done = 0; t = 0;
        while (!done && t < TMO) begin
            @(negedge clk);
            done = m_bvalid[m];
            @(posedge clk); #1;
            t++;
        end
        br[m] = 1'b0;
        chk("wr_resp_hs", {63'd0, done}, 64'd1);
    endtask

    // Master read: called at posedge+1, returns at posedge+1.
    task automatic mread(input int m, input logic [31:0] a, input int rdly, output logic [31:0] d);
        bit done;
        int t;
        d = '0; done = 0; t = 0;
        araddr_d[m] = a; arv[m] = 1'b1;
        while (!done && t < TMO) begin
            @(negedge clk);
            done = m_arready[m];
            @(posedge clk); #1;
            t++;
        end
        arv[m] = 1'b0;
        chk("rd_addr_hs", {63'd0, done}, 64'd1);
        if (rdly > 0) begin repeat (rdly) @(posedge clk); #1; end
        rr[m] = 1'b1; done = 0; t = 0;
        while (!done && t < TMO) begin
            @(negedge clk);
            if (m_rvalid[m]) begin done = 1; d = m_rdata; end
            @(posedge clk); #1;
            t++;
        end
        rr[m] = 1'b0;
        chk("rd_resp_hs", {63'd0, done}, 64'd1);
    endtask

    // Random traffic confined to one master's own address window.
    task automatic rand_master(input int m);
        logic [31:0] base, d, got;
        logic [3:0]  s;
        int idx, n;
        base = (m == 0) ? 32'h200 : 32'h300;
        for (int i = 0; i < 8; i++) begin
            d = $urandom;
            mwrite(m, base + 32'(i * 4), d, 4'hF, int'($urandom_range(0, 2)));
            mdl[(base >> 2) + i] = d;
        end
        for (int k = 0; k < 12; k++) begin
            n = int'($urandom_range(0, 2));
            if (n > 0) begin repeat (n) @(posedge clk); #1; end
            idx = int'($urandom_range(0, 7));
            if ($urandom_range(0, 1) == 1) begin
                d = $urandom;
                s = 4'($urandom_range(1, 15));
                mwrite(m, base + 32'(idx * 4), d, s, int'($urandom_range(0, 3)));
                mdl[(base >> 2) + idx] = merge(mdl[(base >> 2) + idx], d, s);
            end else begin
                mread(m, base + 32'(idx * 4), int'($urandom_range(0, 3)), got);
                chk("rand_rdata", {32'd0, got}, {32'd0, mdl[(base >> 2) + idx]});
            end
        end
    endtask

    typedef struct {
        int          m;
        bit          wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl [10];

    initial begin
        #400000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [31:0] got;
        int t;
        bit done;

        tbl[0] = '{0, 1'b1, 32'h100, 32'hDEADBEEF, 4'hF, 32'h0};
        tbl[1] = '{1, 1'b0, 32'h100, 32'h0,        4'h0, 32'hDEADBEEF};
        tbl[2] = '{1, 1'b1, 32'h104, 32'h12345678, 4'hF, 32'h0};
        tbl[3] = '{0, 1'b1, 32'h104, 32'hAABBCCDD, 4'hC, 32'h0};
        tbl[4] = '{1, 1'b0, 32'h104, 32'h0,        4'h0, 32'hAABB5678};
        tbl[5] = '{0, 1'b1, 32'h100, 32'h00000011, 4'h1, 32'h0};
        tbl[6] = '{0, 1'b0, 32'h100, 32'h0,        4'h0, 32'hDEADBE11};
        tbl[7] = '{1, 1'b1, 32'h108, 32'h11111111, 4'hF, 32'h0};
        tbl[8] = '{1, 1'b1, 32'h108, 32'hCAFEF00D, 4'hA, 32'h0};
        tbl[9] = '{0, 1'b0, 32'h108, 32'h0,        4'h0, 32'hCA11F011};

        // reset state
        clr_drv();
        resetn = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_m_outs", {54'd0, m_awready, m_wready, m_bvalid, m_arready, m_rvalid}, 64'd0);
        chk("reset_s_outs", {59'd0, s_awvalid, s_wvalid, s_bready, s_arvalid, s_rready}, 64'd0);
        @(posedge clk); #1 resetn = 1'b1;
        clr_logs();

        // idle: no ready or valid toward either master
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("idle_quiet", {54'd0, m_awready, m_wready, m_bvalid, m_arready, m_rvalid}, 64'd0);
        end
        @(posedge clk); #1;

        // one-cycle grant latency, m1 write by hand
        awaddr_d[1] = 32'h10C; wdata_d[1] = 32'h0BADF00D; wstrb_d[1] = 4'hF;
        awv[1] = 1'b1; wv[1] = 1'b1;
        @(negedge clk);
        chk("lat_cycle0", {62'd0, s_awvalid, m_awready[1]}, 64'd0);
        @(negedge clk);
        chk("lat_cycle1", {61'd0, s_awvalid, m_awready}, 64'b110);
        chk("lat_addr", {32'd0, s_awaddr}, 64'h10C);
        @(posedge clk); #1;
        awv[1] = 1'b0; wv[1] = 1'b0; br[1] = 1'b1;
        done = 0; t = 0;
        while (!done && t < TMO) begin
            @(negedge clk); done = m_bvalid[1];
            @(posedge clk); #1; t++;
        end
        br[1] = 1'b0;
        chk("lat_bresp", {63'd0, done}, 64'd1);
        mdl[32'h10C >> 2] = 32'h0BADF00D;

        // a request withdrawn before the grant registers is ignored
        awaddr_d[0] = 32'h1F0; awv[0] = 1'b1;
        @(negedge clk); awv[0] = 1'b0;
        @(negedge clk);
        chk("withdraw_no_grant", {62'd0, s_awvalid, m_awready[0]}, 64'd0);
        @(posedge clk); #1;

        // table-driven transactions
        for (int i = 0; i < 10; i++) begin
            if (tbl[i].wr) begin
                mwrite(tbl[i].m, tbl[i].addr, tbl[i].data, tbl[i].strb, 1);
                mdl[tbl[i].addr >> 2] = merge(mdl[tbl[i].addr >> 2], tbl[i].data, tbl[i].strb);
            end else begin
                mread(tbl[i].m, tbl[i].addr, 1, got);
                chk($sformatf("tbl%0d_rdata", i), {32'd0, got}, {32'd0, tbl[i].exp});
            end
        end
        mread(0, 32'h10C, 0, got);
        chk("lat_write_readback", {32'd0, got}, {32'd0, mdl[32'h10C >> 2]});

        // simultaneous awvalid after reset: m0 first, m1 granted after the idle cycle
        do_reset();
        fork
            mwrite(0, 32'h130, 32'h01010101, 4'hF, 2);
            mwrite(1, 32'h134, 32'h02020202, 4'hF, 0);
        join
        chk("sim_order", {32'd0, aw_m[0], aw_m[1]}, {32'd0, 32'd0, 32'd1});
        chk("sim_gap", 64'(aw_c[1] - b_c[0]), 64'd2);

        // continuous streams from both masters alternate
        do_reset();
        fork
            for (int i = 0; i < 4; i++) mwrite(0, 32'h140 + 32'(i * 4), 32'hA0 + 32'(i), 4'hF, 0);
            for (int i = 0; i < 4; i++) mwrite(1, 32'h160 + 32'(i * 4), 32'hB0 + 32'(i), 4'hF, 0);
        join
        chk("stream_count", 64'(aw_m.size()), 64'd8);
        for (int i = 0; i < 8 && i < aw_m.size(); i++)
            chk($sformatf("stream_grant%0d", i), 64'(aw_m[i]), 64'(i % 2));

        // m1 stalls bready: m0 waits for m1's B handshake
        do_reset();
        fork
            mwrite(1, 32'h110, 32'h33333333, 4'hF, 5);
            begin
                repeat (2) @(posedge clk); #1;
                mwrite(0, 32'h114, 32'h44444444, 4'hF, 0);
            end
        join
        chk("stall_order", {32'd0, aw_m[0], aw_m[1]}, {32'd0, 32'd1, 32'd0});
        chk("stall_hold", {63'd0, (b_c[0] - aw_c[0]) >= 5}, 64'd1);
        chk("stall_m0_after_b", 64'(aw_c[1] - b_c[0]), 64'd2);

        // concurrent m0 write and m1 read overlap
        do_reset();
        fork
            mwrite(0, 32'h120, 32'h55555555, 4'hF, 3);
            mread(1, 32'h100, 3, got);
        join
        mdl[32'h120 >> 2] = 32'h55555555;
        chk("conc_rdata", {32'd0, got}, {32'd0, mdl[32'h100 >> 2]});
        chk("conc_same_grant", 64'(ar_c[0]), 64'(aw_c[0]));
        chk("conc_overlap", {62'd0, ar_c[0] < b_c[0], aw_c[0] < r_c[0]}, 64'd3);

        // reset while the write channel is busy
        do_reset();
        awaddr_d[0] = 32'h180; wdata_d[0] = 32'h66666666; wstrb_d[0] = 4'hF;
        awv[0] = 1'b1; wv[0] = 1'b1;
        @(negedge clk); @(negedge clk);
        @(posedge clk); #1;
        awv[0] = 1'b0; wv[0] = 1'b0;
        @(negedge clk); @(negedge clk);
        chk("busy_bvalid_held", {62'd0, m_bvalid}, 64'b01);
        resetn = 1'b0;
        clr_drv();
        #1;
        chk("rst_mid_s", {59'd0, s_awvalid, s_wvalid, s_bready, s_arvalid, s_rready}, 64'd0);
        chk("rst_mid_m", {54'd0, m_awready, m_wready, m_bvalid, m_arready, m_rvalid}, 64'd0);
        @(posedge clk); #1 resetn = 1'b1;
        clr_logs();
        mwrite(1, 32'h184, 32'h77777777, 4'hF, 0);
        mread(1, 32'h184, 0, got);
        chk("post_rst_rdata", {32'd0, got}, 64'h77777777);
        chk("post_rst_grant", {32'd0, aw_m[0]}, 64'd1);

        // randomized traffic against the bench memory model
        fork
            rand_master(0);
            rand_master(1);
        join

        chk("exclusive_routing", 64'(viol), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/dmem_axi_lite_arbiter.md
# dmem_axi_lite_arbiter

Two-master AXI-Lite arbiter that shares one `dmem_axi_lite` data-memory slave between the CPU data port (master 0) and a second requester such as DMA or debug (master 1). Read and write paths are arbitrated independently, each with round-robin fairness. A grant is held from the address request until that master's response handshake completes. The block sits between the interconnect masters and the memory slave and adds one cycle of arbitration latency per transaction.

## Interface
Parameters:
- ADDR_WIDTH, 32, address width per master
- DATA_WIDTH, 32, data width per master

Ports. Master-side buses are packed: master m occupies slice [m*W +: W]. Reset is `resetn`, asynchronous, active-low; clock is `clk`.
- clk  in  1  clock
- resetn  in  1  asynchronous active-low reset
- m_awaddr  in  2*ADDR_WIDTH  write addresses
- m_awvalid  in  2  write address valid
- m_awready  out  2  write address ready
- m_wdata  in  2*DATA_WIDTH  write data
- m_wstrb  in  8  byte strobes, 4 per master
- m_wvalid  in  2  write data valid
- m_wready  out  2  write data ready
- m_bvalid  out  2  write response valid
- m_bready  in  2  write response ready
- m_araddr  in  2*ADDR_WIDTH  read addresses
- m_arvalid  in  2  read address valid
- m_arready  out  2  read address ready
- m_rdata  out  DATA_WIDTH  read data, broadcast to both masters
- m_rvalid  out  2  read data valid
- m_rready  in  2  read data ready
- s_awaddr, s_awvalid, s_wdata, s_wstrb[3:0], s_wvalid, s_bready, s_araddr, s_arvalid, s_rready  out  slave-side request signals, same widths as one master
- s_awready, s_wready, s_bvalid, s_arready, s_rdata, s_rvalid  in  slave-side responses

## Operation
- Write FSM states: W_IDLE, W_BUSY.
  - In W_IDLE, request vector = m_awvalid. If it is non-zero, the round-robin picker selects a master; wgrant is registered and the FSM moves to W_BUSY.
  - In W_BUSY, the granted master's AW, W and B signals pass combinationally to and from the slave. The other master sees awready, wready and bvalid at 0.
  - W_BUSY exits on s_bvalid & m_bready[wgrant]. wprio is set to ~wgrant and the FSM returns to W_IDLE.
- Read FSM states: R_IDLE, R_BUSY, with the same structure.
  - Request vector = m_arvalid.
  - Exit on s_rvalid & m_rready[rgrant]; rprio is set to ~rgrant.
- Picker: if exactly one master requests, it wins. If both request, the master indexed by prio wins.
- All slave-side valids (s_awvalid, s_wvalid, s_arvalid, s_bready, s_rready) are forced to 0 in IDLE. The slave latches the address while valid is high, so s_awvalid and s_arvalid are only driven in BUSY.
- Slave address and data muxes select the granted master, or master 0 in IDLE.
- A read and a write may be in flight at the same time, from the same master or from different masters.
- One outstanding transaction per channel; no pipelining.

## Timing
- Reset values:
  - States IDLE; wgrant = rgrant = 0; wprio = rprio = 0.
  - All m_* ready/valid outputs 0; all s_* valid/ready outputs 0.
- Latency: awvalid in cycle N gives s_awvalid in cycle N+1. Every slave response reaches the master in the same cycle (combinational).
- A request arriving while its channel is BUSY waits. It is evaluated in the first IDLE cycle after completion, so the back-to-back gap is 1 idle cycle.
- A requester withdrawing awvalid/arvalid in IDLE before the grant registers loses nothing. Masters must hold valid until ready per AXI.
- Reset mid-transaction: FSMs return to IDLE immediately and all valids drop. The slave shares resetn.

## Structure
- Package `dmem_arb_pkg` holds the IDLE/BUSY state encodings and the master-count constant NM = 2.
- Sub-module `rr_arb2` is the combinational 2-way round-robin picker (inputs req[1:0], prio; output gnt). It is instantiated once for writes and once for reads.

## Test plan
- Single write: m0 writes 0xDEADBEEF to 0x100 with strobe 0xF, then m1 reads 0x100 -> m1 rdata = 0xDEADBEEF; m1 sees no ready while idle.
- Simultaneous awvalid on both masters after reset -> m0 granted first, m1 granted 1 cycle after m0's B handshake.
- Both masters stream 4 writes each continuously -> grants alternate 0,1,0,1...; no starvation.
- Concurrent read by m1 and write by m0 to different addresses -> both complete and overlap in time.
- Stalled bready: m1 holds bready low for 5 cycles -> grant is held; m0's awvalid is stalled until m1's B handshake.
- resetn pulsed during W_BUSY -> all valids 0 the next cycle, FSM in IDLE, and a subsequent m1 write completes normally.
